// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I front end.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr
);
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_instr    <= NOP_INSTR;
        end else if (i_flush) begin
            // Address fields keep their last value; only validity and the word are scrubbed.
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + 32'd4;
            r_instr    <= i_instr;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, boot/run/fault sequencing, delivery counter and IF/ID capture.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);
    import riscv_pkg::*;

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_fault;
    logic [XLEN-1:0] r_fault_pc;
    logic [XLEN-1:0] r_fetch_count;
    logic            w_load;
    logic            w_flush;
    logic            w_fault_set;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        w_fault_set  = 1'b0;
        case (r_state)
            BOOT: w_state_next = RUN;
            RUN: begin
                if (redirect_en && is_misaligned(redirect_pc)) begin
                    w_state_next = FAULT;
                    w_flush      = 1'b1;
                    w_fault_set  = 1'b1;
                end else if (redirect_en) begin
                    w_pc_next = redirect_pc;
                    w_flush   = 1'b1;
                end else if (!stall) begin
                    w_load    = 1'b1;
                    w_pc_next = r_pc + 32'd4;
                end
            end
            FAULT: w_state_next = FAULT;
            default: w_state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_fault       <= 1'b0;
            r_fault_pc    <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_pc;
            end
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_flush   (w_flush),
        .i_pc      (r_pc),
        .i_instr   (imem_data),
        .o_valid   (id_valid),
        .o_pc      (id_pc),
        .o_pc_plus4(id_pc_plus4),
        .o_instr   (id_instr)
    );

    assign imem_addr   = r_pc;
    assign fault       = r_fault;
    assign fault_pc    = r_fault_pc;
    assign fetch_count = r_fetch_count;
endmodule
